pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, meaning total pipeline stages; legal range 5..8.
REQ-002 SHALL have parameter EX_STAGE, default 2, meaning the stage index that resolves jumps.
REQ-003 SHALL have parameter MEM_STAGE, default 3, meaning the stage index that performs data memory access.
REQ-004 SHALL enforce the constraint 1 < EX_STAGE < MEM_STAGE < NUM_STAGES-1 on the stage-index parameters.
REQ-005 SHALL have parameter RESET_VECTOR, default 32'h00010000, meaning the fetch address after reset.
REQ-006 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have ports decode_rs1 and decode_rs2, input, 5 bits each: source registers of the stage-1 instruction.
REQ-009 SHALL have ports decode_uses_rs1 and decode_uses_rs2, input, 1 bit each: the stage-1 instruction reads the corresponding rs.
REQ-010 SHALL have ports decode_rd (input, 5 bits) and decode_rd_write (input, 1 bit): destination register of the stage-1 instruction and its write flag.
REQ-011 SHALL have port mem_busy, input, 1 bit: the MEM-stage transaction (e.g. MMIO write) has not completed.
REQ-012 SHALL have ports jump_enable (input, 1 bit) and jump_target (input, XLEN bits): EX-stage redirect request and destination.
REQ-013 SHALL have port pc, output, XLEN bits: current fetch address.
REQ-014 SHALL have ports stage_valid and stage_enable, output, NUM_STAGES bits each: per-stage valid flag, and per-stage pipeline-register load enable.
REQ-015 SHALL have ports retire (output, 1 bit) and instret (output, 64 bits): retirement pulse and retired-instruction count.
REQ-016 SHALL have port misaligned_jump, output, 1 bit: sticky flag, set when a taken jump targets an address with nonzero bits [1:0].

Function
REQ-017 SHALL define mem_stall as stage_valid[MEM_STAGE] && mem_busy.
REQ-018 During mem_stall, stages 0..MEM_STAGE SHALL hold, stage MEM_STAGE+1 SHALL receive a bubble (valid cleared), and later stages SHALL advance.
REQ-019 SHALL define hazard as stage_valid[1] and a used rs (nonzero) that equals the rd of any valid, writing instruction in stages 2..NUM_STAGES-1; no forwarding.
REQ-020 During hazard without mem_stall, stages 0 and 1 SHALL hold, stage 2 SHALL receive a bubble, and later stages SHALL advance.
REQ-021 SHALL define jump_taken as stage_valid[EX_STAGE] && jump_enable && !mem_stall; jump_enable SHALL be ignored while mem_stall is high.
REQ-022 On jump_taken, on the next edge pc SHALL become {jump_target[XLEN-1:2],2'b00} and stages 1..EX_STAGE-1 SHALL be invalidated, while stage 0 stays valid.
REQ-023 jump_taken SHALL override hazard, because the hazarding instruction is flushed.
REQ-024 SHALL set misaligned_jump on any jump_taken whose target has bits [1:0] != 0.
REQ-025 When no stall and no jump is active, pc SHALL advance to pc+4 (modulo 2^XLEN) every cycle stage 0 advances.
REQ-026 SHALL track rd and rd_write per stage internally, captured from the decode_* inputs when stage 2 loads and shifted with the valid flags.
REQ-027 Bubbles SHALL carry rd_write=0.
REQ-028 stage_enable[i] SHALL be 1 exactly when stage i loads from stage i-1 on this edge; it SHALL be 0 for holding stages and for stages receiving bubbles.
REQ-029 The last stage SHALL never stall; retire SHALL equal stage_valid[NUM_STAGES-1] combinationally.
REQ-030 instret SHALL increment by 1 each cycle retire is high and SHALL wrap from 2^64-1 to 0.
REQ-031 When mem_stall, hazard and jump_enable coincide, priority SHALL be mem_stall, then jump_taken, then hazard.

Reset
REQ-032 On a clock edge with reset==0, pc SHALL become RESET_VECTOR, stage_valid SHALL become 1 (only stage 0 valid), and instret and misaligned_jump SHALL become 0.
REQ-033 On that same reset edge, all tracked rd_write SHALL become 0.
REQ-034 Reset asserted mid-stall or mid-flush SHALL abandon all in-flight state; retire SHALL be 0 during reset.

Structure
REQ-035 XLEN and a typedef pipe_rd_tag_t {valid, rd[4:0], write} SHALL live in the shared package.
REQ-036 Hazard comparison SHALL be a combinational sub-module hazard_detector, parametrised by NUM_STAGES.

Verification
REQ-037 Straight-line: reset, run 10 cycles with no hazards -> pc = 0x00010000 + 4*n, first retire at cycle 5, instret = 6 after 10 cycles.
REQ-038 RAW: rd=5 writer in stage 2 and decode_rs1=5 used -> 3 bubbles inserted and pc held 3 cycles; rs1=0 -> no stall.
REQ-039 Jump: EX jump_enable with target 0x00010040 -> next pc = 0x00010040 and stage_valid[1] = 0; target 0x00010042 -> pc = 0x00010040 and misaligned_jump = 1.
REQ-040 MMIO stall: mem_busy high 4 cycles with MEM valid -> stages 0..3 frozen, stage 4 gets 4 bubbles, retire low for 4 cycles, no instruction lost.
REQ-041 Simultaneous events: mem_stall with jump_enable -> no redirect until stall clears, then redirect once.
REQ-042 Reset mid-stall: reset low during hazard -> pc = RESET_VECTOR, stage_valid = 1, instret = 0.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// Shared width, per-stage destination tag and stage-action encodings for the
// pipeline control slice.
package pipeline_control_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       write;
  } pipe_rd_tag_t;

  localparam pipe_rd_tag_t EMPTY_TAG = '0;

  // What a stage's pipeline register does on the coming edge.
  localparam logic [1:0] STAGE_LOAD   = 2'd0;
  localparam logic [1:0] STAGE_HOLD   = 2'd1;
  localparam logic [1:0] STAGE_BUBBLE = 2'd2;

  // x0 is hardwired, so a read of it can never depend on an older writer.
  function automatic logic rd_matches(input pipe_rd_tag_t tag, input logic uses,
                                      input logic [4:0] rs);
    return uses && (rs != 5'd0) && tag.valid && tag.write && (tag.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_detector.sv
// Read-after-write detection for the decode-stage instruction against every
// older writer in stages 2 and beyond; there is no forwarding path.
module hazard_detector
  import pipeline_control_pkg::*;
#(
  parameter int NUM_STAGES = 5
) (
  input  logic         decode_valid,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  input  logic         uses_rs1,
  input  logic         uses_rs2,
  input  pipe_rd_tag_t tags [2:NUM_STAGES-1],
  output logic         hazard
);

  logic any_match;

  always_comb begin
    any_match = 1'b0;
    for (int i = 2; i < NUM_STAGES; i++) begin
      if (rd_matches(tags[i], uses_rs1, rs1) || rd_matches(tags[i], uses_rs2, rs2)) begin
        any_match = 1'b1;
      end
    end
  end

  assign hazard = decode_valid && any_match;

endmodule

// File: rtl/pipeline_control.sv
// Pipeline sequencing control: per-stage valid/enable generation for memory
// stalls, RAW interlocks and EX-stage redirects, plus fetch PC and retirement.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int              NUM_STAGES   = 5,
  parameter int              EX_STAGE     = 2,
  parameter int              MEM_STAGE    = 3,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0001_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            decode_rs1,
  input  logic [4:0]            decode_rs2,
  input  logic                  decode_uses_rs1,
  input  logic                  decode_uses_rs2,
  input  logic [4:0]            decode_rd,
  input  logic                  decode_rd_write,
  input  logic                  mem_busy,
  input  logic                  jump_enable,
  input  logic [XLEN-1:0]       jump_target,
  output logic [XLEN-1:0]       pc,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [NUM_STAGES-1:0] stage_enable,
  output logic                  retire,
  output logic [63:0]           instret,
  output logic                  misaligned_jump
);

  if (NUM_STAGES < 5 || NUM_STAGES > 8) begin : g_bad_depth
    $error("pipeline_control: NUM_STAGES must lie in 5..8");
  end
  if (!(1 < EX_STAGE && EX_STAGE < MEM_STAGE && MEM_STAGE < NUM_STAGES - 1)) begin : g_bad_index
    $error("pipeline_control: need 1 < EX_STAGE < MEM_STAGE < NUM_STAGES-1");
  end

  // Stages 0 and 1 only need a valid bit; later stages carry a destination tag.
  logic [1:0]            valid_lo_q, valid_lo_d;
  pipe_rd_tag_t          tag_q [2:NUM_STAGES-1];
  pipe_rd_tag_t          tag_d [2:NUM_STAGES-1];
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [63:0]           instret_q, instret_d;
  logic                  misaligned_q, misaligned_d;

  logic [NUM_STAGES-1:0] valid_now;
  logic [1:0]            action [NUM_STAGES];
  logic                  mem_stall;
  logic                  jump_taken;
  logic                  hazard;

  always_comb begin
    valid_now = '0;
    valid_now[1:0] = valid_lo_q;
    for (int i = 2; i < NUM_STAGES; i++) begin
      valid_now[i] = tag_q[i].valid;
    end
  end

  hazard_detector #(
    .NUM_STAGES (NUM_STAGES)
  ) u_hazard_detector (
    .decode_valid (valid_lo_q[1]),
    .rs1          (decode_rs1),
    .rs2          (decode_rs2),
    .uses_rs1     (decode_uses_rs1),
    .uses_rs2     (decode_uses_rs2),
    .tags         (tag_q),
    .hazard       (hazard)
  );

  assign mem_stall  = valid_now[MEM_STAGE] && mem_busy;
  assign jump_taken = valid_now[EX_STAGE] && jump_enable && !mem_stall;

  // Priority: memory stall, then redirect (which flushes the interlocked
  // instruction), then RAW interlock. A redirect squashes everything younger
  // than the jump, i.e. the slots it leaves behind in stages 1..EX_STAGE.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      action[i] = STAGE_LOAD;
      if (mem_stall) begin
        if (i <= MEM_STAGE) begin
          action[i] = STAGE_HOLD;
        end else if (i == MEM_STAGE + 1) begin
          action[i] = STAGE_BUBBLE;
        end
      end else if (jump_taken) begin
        if (i >= 1 && i <= EX_STAGE) begin
          action[i] = STAGE_BUBBLE;
        end
      end else if (hazard) begin
        if (i <= 1) begin
          action[i] = STAGE_HOLD;
        end else if (i == 2) begin
          action[i] = STAGE_BUBBLE;
        end
      end
    end
  end

  always_comb begin
    pc_d         = pc_q;
    valid_lo_d   = valid_lo_q;
    tag_d        = tag_q;
    instret_d    = instret_q;
    misaligned_d = misaligned_q;

    if (jump_taken) begin
      pc_d = {jump_target[XLEN-1:2], 2'b00};
    end else if (action[0] == STAGE_LOAD) begin
      pc_d = pc_q + XLEN'(4);
    end

    valid_lo_d[0] = 1'b1;
    if (action[1] == STAGE_LOAD) begin
      valid_lo_d[1] = valid_lo_q[0];
    end else if (action[1] == STAGE_BUBBLE) begin
      valid_lo_d[1] = 1'b0;
    end

    // The decode-stage destination is captured as the instruction enters stage 2.
    if (action[2] == STAGE_LOAD) begin
      tag_d[2] = '{valid: valid_lo_q[1], rd: decode_rd, write: decode_rd_write && valid_lo_q[1]};
    end else if (action[2] == STAGE_BUBBLE) begin
      tag_d[2] = EMPTY_TAG;
    end

    for (int i = 3; i < NUM_STAGES; i++) begin
      if (action[i] == STAGE_LOAD) begin
        tag_d[i] = tag_q[i-1];
      end else if (action[i] == STAGE_BUBBLE) begin
        tag_d[i] = EMPTY_TAG;
      end
    end

    if (retire) begin
      instret_d = instret_q + 64'd1;
    end
    if (jump_taken && (jump_target[1:0] != 2'b00)) begin
      misaligned_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      valid_lo_q   <= 2'b01;
      instret_q    <= 64'd0;
      misaligned_q <= 1'b0;
      for (int i = 2; i < NUM_STAGES; i++) begin
        tag_q[i] <= EMPTY_TAG;
      end
    end else begin
      pc_q         <= pc_d;
      valid_lo_q   <= valid_lo_d;
      instret_q    <= instret_d;
      misaligned_q <= misaligned_d;
      for (int i = 2; i < NUM_STAGES; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  always_comb begin
    stage_enable = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_enable[i] = reset && (action[i] == STAGE_LOAD);
    end
  end

  assign pc              = pc_q;
  assign stage_valid     = valid_now;
  assign retire          = reset && valid_now[NUM_STAGES-1];
  assign instret         = instret_q;
  assign misaligned_jump = misaligned_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: a queue-based pipeline model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_pipeline_control;
  import pipeline_control_pkg::*;

  localparam int          N   = 5;
  localparam int          EX  = 2;
  localparam int          MEM = 3;
  localparam logic [31:0] RV  = 32'h0001_0000;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    decode_rs1, decode_rs2, decode_rd;
  logic          decode_uses_rs1, decode_uses_rs2, decode_rd_write;
  logic          mem_busy, jump_enable;
  logic [31:0]   jump_target;
  logic [31:0]   pc;
  logic [N-1:0]  stage_valid, stage_enable;
  logic          retire;
  logic [63:0]   instret;
  logic          misaligned_jump;

  always #5 clock = ~clock;

  pipeline_control #(
    .NUM_STAGES   (N),
    .EX_STAGE     (EX),
    .MEM_STAGE    (MEM),
    .RESET_VECTOR (RV)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .decode_rs1      (decode_rs1),
    .decode_rs2      (decode_rs2),
    .decode_uses_rs1 (decode_uses_rs1),
    .decode_uses_rs2 (decode_uses_rs2),
    .decode_rd       (decode_rd),
    .decode_rd_write (decode_rd_write),
    .mem_busy        (mem_busy),
    .jump_enable     (jump_enable),
    .jump_target     (jump_target),
    .pc              (pc),
    .stage_valid     (stage_valid),
    .stage_enable    (stage_enable),
    .retire          (retire),
    .instret         (instret),
    .misaligned_jump (misaligned_jump)
  );

  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       wr;
  } slot_t;

  typedef struct {
    bit [31:0]  pc;
    bit [N-1:0] valid;
    bit [N-1:0] enable;
    bit         retire;
    bit [63:0]  instret;
    bit         mis;
  } exp_t;

  // Model: pipe[0] is the fetch slot, pipe[N-1] the oldest instruction.
  slot_t     pipe[$];
  exp_t      expQ[$];
  bit [31:0] mPc;
  bit [63:0] mInstret;
  bit        mMis;
  int        total = 0;
  int        bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  function automatic void resetModel();
    slot_t s;
    pipe.delete();
    for (int i = 0; i < N; i++) begin
      s.valid = (i == 0);
      s.rd    = 5'd0;
      s.wr    = 1'b0;
      pipe.push_back(s);
    end
    mPc      = RV;
    mInstret = 64'd0;
    mMis     = 1'b0;
  endfunction

  // Drive one cycle of inputs, push the outputs the model predicts for this
  // cycle, then advance the model across the coming edge.
  task automatic applyStimulus(input bit rst, input bit [4:0] rs1, input bit u1,
                               input bit [4:0] rs2, input bit u2, input bit [4:0] rd,
                               input bit wr, input bit busy, input bit jen,
                               input bit [31:0] tgt);
    exp_t  e;
    slot_t bubble;
    slot_t s;
    bit    memStall, jump, haz;
    int    frozen;

    @(posedge clock);
    #1;
    reset = rst; decode_rs1 = rs1; decode_uses_rs1 = u1; decode_rs2 = rs2;
    decode_uses_rs2 = u2; decode_rd = rd; decode_rd_write = wr;
    mem_busy = busy; jump_enable = jen; jump_target = tgt;

    bubble = '{valid: 1'b0, rd: 5'd0, wr: 1'b0};
    memStall = pipe[MEM].valid && busy;
    jump     = pipe[EX].valid && jen && !memStall;
    haz      = 1'b0;
    if (pipe[1].valid) begin
      for (int j = 2; j < N; j++) begin
        if (pipe[j].valid && pipe[j].wr && pipe[j].rd != 5'd0 &&
            ((u1 && rs1 == pipe[j].rd) || (u2 && rs2 == pipe[j].rd))) haz = 1'b1;
      end
    end

    e.pc      = mPc;
    e.instret = mInstret;
    e.mis     = mMis;
    e.retire  = rst && pipe[N-1].valid;
    for (int i = 0; i < N; i++) e.valid[i] = pipe[i].valid;
    e.enable  = '0;

    if (!rst) begin
      resetModel();
    end else begin
      if (e.retire) mInstret++;
      if (jump && tgt[1:0] != 2'b00) mMis = 1'b1;
      s = pipe[1]; s.rd = rd; s.wr = wr; pipe[1] = s;
      if (memStall) frozen = MEM + 1;
      else if (jump) frozen = 0;
      else if (haz) frozen = 2;
      else frozen = 0;
      void'(pipe.pop_back());
      if (frozen > 0) begin
        pipe.insert(frozen, bubble);
      end else begin
        s = '{valid: 1'b1, rd: 5'd0, wr: 1'b0};
        pipe.push_front(s);
      end
      for (int i = 0; i < N; i++) e.enable[i] = (frozen == 0) || (i > frozen);
      if (jump) begin
        for (int i = 1; i <= EX; i++) begin
          pipe[i] = bubble;
          e.enable[i] = 1'b0;
        end
        mPc = {tgt[31:2], 2'b00};
      end else if (frozen == 0) begin
        mPc = mPc + 32'd4;
      end
    end
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc", 64'(pc), 64'(e.pc));
        checkOutput("stage_valid", 64'(stage_valid), 64'(e.valid));
        checkOutput("stage_enable", 64'(stage_enable), 64'(e.enable));
        checkOutput("retire", 64'(retire), 64'(e.retire));
        checkOutput("instret", instret, e.instret);
        checkOutput("misaligned_jump", 64'(misaligned_jump), 64'(e.mis));
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; decode_rs1 = '0; decode_rs2 = '0; decode_rd = '0;
    decode_uses_rs1 = 1'b0; decode_uses_rs2 = 1'b0; decode_rd_write = 1'b0;
    mem_busy = 1'b0; jump_enable = 1'b0; jump_target = '0;
    resetModel();

    $display("[TB] straight-line run");
    doReset();
    idle(11);
    @(negedge clock);
    checkOutput("straight_pc", 64'(pc), 64'(RV + 32'd40));
    checkOutput("straight_instret", instret, 64'd6);

    $display("[TB] RAW interlock on x5");
    doReset();
    idle(1);
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    checkOutput("raw_pc_held", 64'(pc), 64'(RV + 32'd8));
    checkOutput("raw_bubbles", 64'(stage_valid), 64'(5'b00011));

    $display("[TB] x0 source never interlocks");
    doReset();
    idle(1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    @(negedge clock);
    checkOutput("x0_pc", 64'(pc), 64'(RV + 32'd12));

    $display("[TB] aligned then misaligned jump");
    doReset();
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, RV + 32'h40);
    idle(1);
    @(negedge clock);
    checkOutput("jump_pc", 64'(pc), 64'(RV + 32'h40));
    checkOutput("jump_flush_s1", 64'(stage_valid[1]), 64'd0);
    idle(1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, RV + 32'h42);
    idle(1);
    @(negedge clock);
    checkOutput("misjump_pc", 64'(pc), 64'(RV + 32'h40));
    checkOutput("misjump_flag", 64'(misaligned_jump), 64'd1);

    $display("[TB] MMIO stall for four cycles");
    doReset();
    idle(3);
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(6);

    $display("[TB] stall overlapping a jump request");
    doReset();
    idle(3);
    for (int k = 0; k < 2; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, RV + 32'h80);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, RV + 32'h80);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, RV + 32'h80);
    @(negedge clock);
    checkOutput("stalljump_pc", 64'(pc), 64'(RV + 32'h80));
    idle(3);

    $display("[TB] pc wrap at top of address space");
    doReset();
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    idle(3);

    $display("[TB] reset during interlock");
    doReset();
    idle(1);
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    idle(1);
    @(negedge clock);
    checkOutput("midreset_pc", 64'(pc), 64'(RV));
    checkOutput("midreset_valid", 64'(stage_valid), 64'd1);
    checkOutput("midreset_instret", instret, 64'd0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 59) != 0,
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                    RV + 32'($urandom_range(0, 1023)));
    end

    for (int k = 0; k < 4 && expQ.size() > 0; k++) @(negedge clock);
    @(negedge clock);
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
